// File: rtl/target_pkg.sv
// Shared definitions for the target game controller and its helpers.
// The defaults below are also reused by the score converter bench.
package target_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEFAULT_HIT_POINTS = 250;
    localparam int DEFAULT_DEBOUNCE   = 4;

    function automatic logic lfsr_feedback(input logic [15:0] value);
        return ^(value & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One photodiode channel: two-flop synchroniser, debounce filter and a
// registered strobe for a filtered 1->0 transition.
module sensor_debounce
    import target_pkg::*;
#(
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic fall
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic          filt_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          fall_q;
    logic          fall_d;

    // Only an unbroken run of disagreeing samples moves the filtered level
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = filt_dly_q & ~filt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            cnt_q      <= '0;
            fall_q     <= 1'b0;
        end else begin
            sync1_q    <= raw_n;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            cnt_q      <= cnt_d;
            fall_q     <= fall_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/target_game_ctrl.sv
// Photo-sensor target game: keeps NUM_TARGETS distinct pseudo-random targets
// lit, scores debounced hits, counts timeouts as misses and ends the round.
module target_game_ctrl
    import target_pkg::*;
#(
    parameter int          NUM_SENSORS   = 10,
    parameter int          NUM_TARGETS   = 2,
    parameter int          IDX_W         = 4,
    parameter int          SCORE_W       = 32,
    parameter int          HIT_POINTS    = DEFAULT_HIT_POINTS,
    parameter int          DEBOUNCE      = DEFAULT_DEBOUNCE,
    parameter int unsigned TARGET_CYCLES = 50_000_000,
    parameter int unsigned GAME_CYCLES   = 1_500_000_000,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_SENSORS-1:0]       photo_array,
    output logic [NUM_TARGETS*IDX_W-1:0] target_idx,
    output logic [NUM_TARGETS-1:0]       target_valid,
    output logic [SCORE_W-1:0]           score,
    output logic [15:0]                  miss_count,
    output logic [NUM_TARGETS-1:0]       hit_pulse,
    output logic                         game_over
);
    localparam int TW = (TARGET_CYCLES > 1) ? $clog2(TARGET_CYCLES) : 1;
    localparam int GW = (GAME_CYCLES > 1) ? $clog2(GAME_CYCLES) : 1;
    localparam logic [TW-1:0]    SLOT_LAST = TW'(TARGET_CYCLES - 1);
    localparam logic [GW-1:0]    GAME_LAST = GW'(GAME_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_SENSORS - 1);

    game_state_e         state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [15:0]         miss_q, miss_d;
    logic [NUM_TARGETS-1:0] hit_q, hit_d;
    logic [NUM_TARGETS-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]    idx_q [NUM_TARGETS];
    logic [IDX_W-1:0]    idx_d [NUM_TARGETS];
    logic [TW-1:0]       slot_tmr_q [NUM_TARGETS];
    logic [TW-1:0]       slot_tmr_d [NUM_TARGETS];
    logic [GW-1:0]       game_tmr_q, game_tmr_d;

    logic [NUM_SENSORS-1:0]  fall;
    logic [(2**IDX_W)-1:0]   fall_pad;
    logic [IDX_W-1:0]        candidate;
    logic [NUM_TARGETS-1:0]  hit_mask;
    logic [NUM_TARGETS-1:0]  miss_mask;
    logic [NUM_TARGETS-1:0]  assign_mask;
    logic                    enter_play;
    int                      hit_cnt;
    int                      miss_cnt;
    logic [SCORE_W:0]        score_sum;
    logic [16:0]             miss_sum;
    logic [IDX_W-1:0]        cand;
    logic                    clash;

    for (genvar s = 0; s < NUM_SENSORS; s++) begin : g_sensor
        sensor_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .clock (clock),
            .reset (reset),
            .raw_n (photo_array[s]),
            .fall  (fall[s])
        );
    end

    // Padding lets any IDX_W-wide index address the fall vector safely
    always_comb begin
        fall_pad                  = '0;
        fall_pad[NUM_SENSORS-1:0] = fall;
    end

    assign candidate = IDX_W'({16'd0, lfsr_q} % NUM_SENSORS);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_feedback(lfsr_q)};
        score_d     = score_q;
        miss_d      = miss_q;
        hit_d       = '0;
        valid_d     = valid_q;
        idx_d       = idx_q;
        slot_tmr_d  = slot_tmr_q;
        game_tmr_d  = game_tmr_q;
        hit_mask    = '0;
        miss_mask   = '0;
        assign_mask = '0;
        enter_play  = 1'b0;
        hit_cnt     = 0;
        miss_cnt    = 0;
        score_sum   = '0;
        miss_sum    = '0;
        cand        = '0;
        clash       = 1'b0;

        unique case (state_q)
            IDLE, OVER: begin
                enter_play = start;
            end
            PLAY: begin
                // A hit in the timeout cycle wins and suppresses the miss
                for (int k = 0; k < NUM_TARGETS; k++) begin
                    if (fall_pad[idx_q[k]]) begin
                        hit_mask[k] = 1'b1;
                        hit_cnt     = hit_cnt + 1;
                    end else if (slot_tmr_q[k] == SLOT_LAST) begin
                        miss_mask[k] = 1'b1;
                        miss_cnt     = miss_cnt + 1;
                    end else begin
                        slot_tmr_d[k] = slot_tmr_q[k] + 1'b1;
                    end
                end

                score_sum = {1'b0, score_q} + (SCORE_W+1)'(hit_cnt * HIT_POINTS);
                score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                miss_sum  = {1'b0, miss_q} + 17'(miss_cnt);
                miss_d    = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];

                hit_d       = hit_mask;
                assign_mask = hit_mask | miss_mask;

                if (game_tmr_q == GAME_LAST) begin
                    state_d = OVER;
                    valid_d = '0;
                end else begin
                    game_tmr_d = game_tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_play) begin
            state_d     = PLAY;
            score_d     = '0;
            miss_d      = '0;
            game_tmr_d  = '0;
            valid_d     = '1;
            assign_mask = '1;
        end

        // Lower slots settle first; higher slots avoid their fresh indices.
        // A higher slot being replaced this cycle no longer blocks its old index.
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (assign_mask[k]) begin
                cand = candidate;
                for (int r = 0; r < NUM_TARGETS; r++) begin
                    clash = 1'b0;
                    for (int j = 0; j < NUM_TARGETS; j++) begin
                        if (j < k) begin
                            clash = clash | (idx_d[j] == cand);
                        end else if (j > k && !assign_mask[j]) begin
                            clash = clash | (idx_q[j] == cand);
                        end
                    end
                    if (clash) begin
                        cand = (cand == IDX_LAST) ? '0 : cand + 1'b1;
                    end
                end
                idx_d[k]      = cand;
                slot_tmr_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            score_q    <= '0;
            miss_q     <= '0;
            hit_q      <= '0;
            valid_q    <= '0;
            game_tmr_q <= '0;
            for (int k = 0; k < NUM_TARGETS; k++) begin
                idx_q[k]      <= '0;
                slot_tmr_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            score_q    <= score_d;
            miss_q     <= miss_d;
            hit_q      <= hit_d;
            valid_q    <= valid_d;
            game_tmr_q <= game_tmr_d;
            idx_q      <= idx_d;
            slot_tmr_q <= slot_tmr_d;
        end
    end

    always_comb begin
        target_idx = '0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            target_idx[k*IDX_W +: IDX_W] = idx_q[k];
        end
    end

    assign target_valid = valid_q;
    assign score        = score_q;
    assign miss_count   = miss_q;
    assign hit_pulse    = hit_q;
    assign game_over    = (state_q == OVER);

endmodule

// File: tb/tb_target_game_ctrl.sv
// Directed bench for target_game_ctrl with short target and game timers.
module tb_target_game_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  photo_array;
    logic [7:0]  target_idx;
    logic [1:0]  target_valid;
    logic [31:0] score;
    logic [15:0] miss_count;
    logic [1:0]  hit_pulse;
    logic        game_over;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] i0, i1, n0, n1;
    int u;

    target_game_ctrl #(
        .NUM_SENSORS   (10),
        .NUM_TARGETS   (2),
        .IDX_W         (4),
        .SCORE_W       (32),
        .HIT_POINTS    (250),
        .DEBOUNCE      (4),
        .TARGET_CYCLES (100),
        .GAME_CYCLES   (1000),
        .SEED          (16'hACE1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .photo_array  (photo_array),
        .target_idx   (target_idx),
        .target_valid (target_valid),
        .score        (score),
        .miss_count   (miss_count),
        .hit_pulse    (hit_pulse),
        .game_over    (game_over)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        start       = 1'b0;
        photo_array = '1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        i0 = target_idx[3:0];
        i1 = target_idx[7:4];
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (target_valid !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 00", target_valid); end
        n_cmp++; if (target_idx !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_idx: got %h want 00", target_idx); end
        n_cmp++; if (score !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (miss_count !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_miss: got %0d want 0", miss_count); end
        n_cmp++; if ({hit_pulse, game_over} !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_flags: got %b want 000", {hit_pulse, game_over}); end
    endtask

    task automatic test_start();
        do_reset();
        step(3);
        do_start();
        n_cmp++; if (target_valid !== 2'b11) begin n_bad++; $display("[TB] FAIL start_valid: got %b want 11", target_valid); end
        n_cmp++; if (i0 == i1 || i0 > 4'd9 || i1 > 4'd9) begin n_bad++; $display("[TB] FAIL start_idx: got %0d,%0d want distinct <10", i0, i1); end
        n_cmp++; if (score !== 32'd0) begin n_bad++; $display("[TB] FAIL start_score: got %0d want 0", score); end
    endtask

    task automatic test_hit();
        do_reset();
        do_start();
        photo_array[i0] = 1'b0;
        step(7);
        n_cmp++; if (score !== 32'd0) begin n_bad++; $display("[TB] FAIL hit_early_score: got %0d want 0", score); end
        n_cmp++; if (hit_pulse !== 2'b00) begin n_bad++; $display("[TB] FAIL hit_early_pulse: got %b want 00", hit_pulse); end
        step(1);
        n0 = target_idx[3:0];
        n_cmp++; if (score !== 32'd250) begin n_bad++; $display("[TB] FAIL hit_score: got %0d want 250", score); end
        n_cmp++; if (hit_pulse !== 2'b01) begin n_bad++; $display("[TB] FAIL hit_pulse: got %b want 01", hit_pulse); end
        n_cmp++; if (n0 == target_idx[7:4] || n0 > 4'd9) begin n_bad++; $display("[TB] FAIL hit_newidx: got %0d want !=%0d and <10", n0, target_idx[7:4]); end
        n_cmp++; if (target_idx[7:4] !== i1) begin n_bad++; $display("[TB] FAIL hit_slot1_kept: got %0d want %0d", target_idx[7:4], i1); end
        step(1);
        n_cmp++; if (hit_pulse !== 2'b00) begin n_bad++; $display("[TB] FAIL hit_pulse_clear: got %b want 00", hit_pulse); end
        step(1);
        photo_array = '1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        n_cmp++; if (score !== 32'd250) begin n_bad++; $display("[TB] FAIL start_in_play_score: got %0d want 250", score); end
        n_cmp++; if (target_valid !== 2'b11) begin n_bad++; $display("[TB] FAIL start_in_play_valid: got %b want 11", target_valid); end
    endtask

    task automatic test_glitch_unlit();
        do_reset();
        do_start();
        photo_array[i0] = 1'b0;
        step(3);
        photo_array = '1;
        step(10);
        n_cmp++; if (score !== 32'd0) begin n_bad++; $display("[TB] FAIL glitch_score: got %0d want 0", score); end
        u = 0;
        for (int s = 9; s >= 0; s--) if (4'(s) != target_idx[3:0] && 4'(s) != target_idx[7:4]) u = s;
        photo_array[u] = 1'b0;
        step(10);
        photo_array = '1;
        step(4);
        n_cmp++; if (score !== 32'd0) begin n_bad++; $display("[TB] FAIL unlit_score: got %0d want 0", score); end
    endtask

    task automatic test_both();
        do_reset();
        do_start();
        photo_array[i0] = 1'b0;
        photo_array[i1] = 1'b0;
        step(7);
        n_cmp++; if (score !== 32'd0) begin n_bad++; $display("[TB] FAIL both_early_score: got %0d want 0", score); end
        step(1);
        n0 = target_idx[3:0];
        n1 = target_idx[7:4];
        n_cmp++; if (score !== 32'd500) begin n_bad++; $display("[TB] FAIL both_score: got %0d want 500", score); end
        n_cmp++; if (hit_pulse !== 2'b11) begin n_bad++; $display("[TB] FAIL both_pulse: got %b want 11", hit_pulse); end
        n_cmp++; if (n0 == n1 || n0 > 4'd9 || n1 > 4'd9) begin n_bad++; $display("[TB] FAIL both_newidx: got %0d,%0d want distinct <10", n0, n1); end
        n_cmp++; if (target_valid !== 2'b11) begin n_bad++; $display("[TB] FAIL both_valid: got %b want 11", target_valid); end
        photo_array = '1;
    endtask

    task automatic test_timeout();
        do_reset();
        do_start();
        photo_array[i0] = 1'b0;
        step(8);
        photo_array = '1;
        step(91);
        n_cmp++; if (miss_count !== 16'd0) begin n_bad++; $display("[TB] FAIL timeout_before: got %0d want 0", miss_count); end
        step(1);
        n_cmp++; if (miss_count !== 16'd1) begin n_bad++; $display("[TB] FAIL timeout_slot1: got %0d want 1", miss_count); end
        n_cmp++; if (hit_pulse !== 2'b00) begin n_bad++; $display("[TB] FAIL timeout_pulse: got %b want 00", hit_pulse); end
        n_cmp++; if (target_idx[3:0] == target_idx[7:4]) begin n_bad++; $display("[TB] FAIL timeout_idx: got %0d,%0d want distinct", target_idx[3:0], target_idx[7:4]); end
        step(7);
        n_cmp++; if (miss_count !== 16'd1) begin n_bad++; $display("[TB] FAIL timeout_slot0_before: got %0d want 1", miss_count); end
        step(1);
        n_cmp++; if (miss_count !== 16'd2) begin n_bad++; $display("[TB] FAIL timeout_slot0: got %0d want 2", miss_count); end
        n_cmp++; if (score !== 32'd250) begin n_bad++; $display("[TB] FAIL timeout_score: got %0d want 250", score); end
    endtask

    task automatic test_hit_at_timeout();
        do_reset();
        do_start();
        step(92);
        photo_array[i0] = 1'b0;
        step(7);
        n_cmp++; if (score !== 32'd0 || miss_count !== 16'd0) begin n_bad++; $display("[TB] FAIL edge_before: got %0d/%0d want 0/0", score, miss_count); end
        step(1);
        n_cmp++; if (score !== 32'd250) begin n_bad++; $display("[TB] FAIL edge_score: got %0d want 250", score); end
        n_cmp++; if (miss_count !== 16'd1) begin n_bad++; $display("[TB] FAIL edge_miss: got %0d want 1", miss_count); end
        n_cmp++; if (hit_pulse !== 2'b01) begin n_bad++; $display("[TB] FAIL edge_pulse: got %b want 01", hit_pulse); end
        photo_array = '1;
    endtask

    task automatic test_game_over();
        do_reset();
        do_start();
        photo_array[i0] = 1'b0;
        step(8);
        photo_array = '1;
        step(991);
        n_cmp++; if (game_over !== 1'b0 || target_valid !== 2'b11) begin n_bad++; $display("[TB] FAIL over_early: got %b/%b want 0/11", game_over, target_valid); end
        n_cmp++; if (miss_count !== 16'd18) begin n_bad++; $display("[TB] FAIL over_early_miss: got %0d want 18", miss_count); end
        step(1);
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("[TB] FAIL over_flag: got %b want 1", game_over); end
        n_cmp++; if (target_valid !== 2'b00) begin n_bad++; $display("[TB] FAIL over_valid: got %b want 00", target_valid); end
        n_cmp++; if (miss_count !== 16'd19) begin n_bad++; $display("[TB] FAIL over_miss: got %0d want 19", miss_count); end
        step(5);
        n_cmp++; if (score !== 32'd250 || miss_count !== 16'd19) begin n_bad++; $display("[TB] FAIL over_hold: got %0d/%0d want 250/19", score, miss_count); end
        do_start();
        n_cmp++; if (score !== 32'd0 || miss_count !== 16'd0) begin n_bad++; $display("[TB] FAIL restart_clear: got %0d/%0d want 0/0", score, miss_count); end
        n_cmp++; if (game_over !== 1'b0 || target_valid !== 2'b11) begin n_bad++; $display("[TB] FAIL restart_state: got %b/%b want 0/11", game_over, target_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start();
        photo_array[i0] = 1'b0;
        step(8);
        photo_array = '1;
        step(10);
        reset = 1'b1;
        step(1);
        n_cmp++; if (score !== 32'd0) begin n_bad++; $display("[TB] FAIL mid_reset_score: got %0d want 0", score); end
        n_cmp++; if (target_valid !== 2'b00 || target_idx !== 8'h00) begin n_bad++; $display("[TB] FAIL mid_reset_targets: got %b/%h want 00/00", target_valid, target_idx); end
        n_cmp++; if ({hit_pulse, game_over} !== 3'b000 || miss_count !== 16'd0) begin n_bad++; $display("[TB] FAIL mid_reset_flags: got %b/%0d want 000/0", {hit_pulse, game_over}, miss_count); end
        reset = 1'b0;
        step(3);
        n_cmp++; if (target_valid !== 2'b00) begin n_bad++; $display("[TB] FAIL mid_reset_idle: got %b want 00", target_valid); end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        photo_array = '1;
        test_reset();
        test_start();
        test_hit();
        test_glitch_unlit();
        test_both();
        test_timeout();
        test_hit_at_timeout();
        test_game_over();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
